// File: rtl/axi_wr_arb_pkg.sv
// Shared types and constants for the multi-channel AXI write arbiter.
package axi_wr_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    AW,
    W,
    B,
    DONE
  } state_e;

  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam int unsigned PAGE_4K = 4096;

  // Ceiling log2 for elaboration-time sizing.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/axi_wr_ch_arbiter_rr_arbiter.sv
// Round-robin arbiter: first requester after the last winner, wrapping.
module rr_arbiter #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned IDX_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] req_i,
  input  logic              en_i,
  output logic [NUM_CH-1:0] gnt_o,
  output logic [IDX_W-1:0]  idx_o
);

  logic [IDX_W-1:0] ptr_q;
  logic             found;

  // Scan channels starting one past the pointer; the first requester wins.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    for (int unsigned i = 1; i <= NUM_CH; i++) begin
      int unsigned c;
      c = (32'(ptr_q) + i) % NUM_CH;
      if (!found && req_i[c]) begin
        found    = 1'b1;
        gnt_o[c] = 1'b1;
        idx_o    = IDX_W'(c);
      end
    end
  end

  // Pointer tracks the most recent winner; reset value makes channel 0 first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= IDX_W'(NUM_CH - 1);
    end else if (en_i) begin
      ptr_q <= idx_o;
    end
  end

endmodule

// File: rtl/axi_wr_ch_arbiter.sv
// Multi-channel AXI4 write arbiter: round-robin grant, one burst in flight,
// local rejection of oversize / 4KB-crossing bursts, per-channel status.
module axi_wr_ch_arbiter
  import axi_wr_arb_pkg::*;
#(
  parameter int unsigned NUM_CH        = 4,
  parameter int unsigned ADDR_WIDTH    = 32,
  parameter int unsigned DATA_WIDTH    = 64,
  parameter int unsigned ID_WIDTH      = 3,
  parameter int unsigned MAX_BURST_LEN = 64
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_CH-1:0]              ch_req,
  input  logic [NUM_CH*ADDR_WIDTH-1:0]   ch_addr,
  input  logic [NUM_CH*8-1:0]            ch_len,
  input  logic [NUM_CH*DATA_WIDTH-1:0]   ch_wdata,
  output logic [NUM_CH-1:0]              ch_grant,
  output logic [NUM_CH-1:0]              ch_beat_ack,
  output logic [NUM_CH-1:0]              ch_done,
  output logic [NUM_CH-1:0]              ch_err,
  output logic [ID_WIDTH-1:0]            axi_awid,
  output logic [ADDR_WIDTH-1:0]          axi_awaddr,
  output logic [7:0]                     axi_awlen,
  output logic [2:0]                     axi_awsize,
  output logic [1:0]                     axi_awburst,
  output logic                           axi_awvalid,
  input  logic                           axi_awready,
  output logic [DATA_WIDTH-1:0]          axi_wdata,
  output logic [DATA_WIDTH/8-1:0]        axi_wstrb,
  output logic                           axi_wlast,
  output logic                           axi_wvalid,
  input  logic                           axi_wready,
  input  logic [ID_WIDTH-1:0]            axi_bid,
  input  logic [1:0]                     axi_bresp,
  input  logic                           axi_bvalid,
  output logic                           axi_bready
);

  localparam int unsigned IDX_W  = clog2(NUM_CH);
  localparam int unsigned BYTES  = DATA_WIDTH / 8;
  localparam logic [2:0]  AWSIZE = 3'(clog2(BYTES));

  state_e                 state_q, state_d;
  logic [NUM_CH-1:0]      grant_q;
  logic [IDX_W-1:0]       idx_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [7:0]             len_q;
  logic [7:0]             cnt_q;
  logic                   err_q;
  logic                   awvalid_q;

  logic                   arb_en;
  logic [NUM_CH-1:0]      arb_gnt;
  logic [IDX_W-1:0]       arb_idx;
  logic [ADDR_WIDTH-1:0]  sel_addr;
  logic [7:0]             sel_len;
  logic [15:0]            beats;
  logic [15:0]            burst_end;
  logic                   illegal;

  assign arb_en = (state_q == IDLE) && (|ch_req);

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .IDX_W  (IDX_W)
  ) u_rr (
    .clk   (clk),
    .rst   (rst),
    .req_i (ch_req),
    .en_i  (arb_en),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx)
  );

  // Legality of the winning channel's burst, computed wide enough to never wrap.
  always_comb begin
    sel_addr  = ch_addr[arb_idx*ADDR_WIDTH +: ADDR_WIDTH];
    sel_len   = ch_len[arb_idx*8 +: 8];
    beats     = 16'(sel_len) + 16'd1;
    burst_end = 16'(sel_addr[11:0]) + beats * 16'(BYTES);
    illegal   = (beats > 16'(MAX_BURST_LEN)) || (burst_end > 16'(PAGE_4K));
  end

  // Burst sequencing: IDLE -> AW -> W -> B -> DONE, or IDLE -> DONE on reject.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (|ch_req) state_d = illegal ? DONE : AW;
      AW:   if (axi_awready) state_d = W;
      W:    if (axi_wready && (cnt_q == len_q)) state_d = B;
      B:    if (axi_bvalid) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, grant, latched burst parameters, beat counter and status.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      idx_q     <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      awvalid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      awvalid_q <= (state_d == AW);
      case (state_q)
        IDLE: if (arb_en) begin
          grant_q <= arb_gnt;
          idx_q   <= arb_idx;
          addr_q  <= sel_addr;
          len_q   <= sel_len;
          cnt_q   <= '0;
          err_q   <= illegal;
        end
        W:    if (axi_wready) cnt_q <= cnt_q + 8'd1;
        B:    if (axi_bvalid) err_q <= (axi_bresp != AXI_RESP_OKAY) ||
                                       (axi_bid != ID_WIDTH'(idx_q));
        DONE: grant_q <= '0;
        default: ;
      endcase
    end
  end

  // Write data follows whichever channel holds the grant.
  always_comb begin
    axi_wdata = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (grant_q[i]) axi_wdata = axi_wdata | ch_wdata[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign axi_awid    = ID_WIDTH'(idx_q);
  assign axi_awaddr  = addr_q;
  assign axi_awlen   = len_q;
  assign axi_awsize  = AWSIZE;
  assign axi_awburst = AXI_BURST_INCR;
  assign axi_awvalid = awvalid_q;
  assign axi_wstrb   = '1;
  assign axi_wvalid  = (state_q == W);
  assign axi_wlast   = (state_q == W) && (cnt_q == len_q);
  assign axi_bready  = (state_q == B);

  assign ch_grant    = grant_q;
  assign ch_beat_ack = ((state_q == W) && axi_wready) ? grant_q : '0;
  assign ch_done     = (state_q == DONE) ? grant_q : '0;
  assign ch_err      = ((state_q == DONE) && err_q) ? grant_q : '0;

endmodule

// File: tb/tb_axi_wr_ch_arbiter.sv
// Self-checking bench for axi_wr_ch_arbiter: directed scenarios followed by
// randomized traffic, checked against a transaction-level reference model.
module tb_axi_wr_ch_arbiter;

  localparam int NCH = 4;
  localparam int AWD = 32;
  localparam int DW  = 64;
  localparam int IW  = 3;
  localparam int MBL = 64;

  logic                clk = 1'b0;
  logic                rst;
  logic [NCH-1:0]      ch_req;
  logic [NCH*AWD-1:0]  ch_addr;
  logic [NCH*8-1:0]    ch_len;
  logic [NCH*DW-1:0]   ch_wdata;
  logic [NCH-1:0]      ch_grant, ch_beat_ack, ch_done, ch_err;
  logic [IW-1:0]       axi_awid;
  logic [AWD-1:0]      axi_awaddr;
  logic [7:0]          axi_awlen;
  logic [2:0]          axi_awsize;
  logic [1:0]          axi_awburst;
  logic                axi_awvalid, axi_awready;
  logic [DW-1:0]       axi_wdata;
  logic [DW/8-1:0]     axi_wstrb;
  logic                axi_wlast, axi_wvalid, axi_wready;
  logic [IW-1:0]       axi_bid;
  logic [1:0]          axi_bresp;
  logic                axi_bvalid, axi_bready;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state
  int          model_ptr;
  logic [31:0] m_addr [NCH];
  logic [7:0]  m_len  [NCH];
  logic [31:0] m_salt [NCH];

  always #5 clk = ~clk;

  axi_wr_ch_arbiter #(
    .NUM_CH        (NCH),
    .ADDR_WIDTH    (AWD),
    .DATA_WIDTH    (DW),
    .ID_WIDTH      (IW),
    .MAX_BURST_LEN (MBL)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ch_req      (ch_req),
    .ch_addr     (ch_addr),
    .ch_len      (ch_len),
    .ch_wdata    (ch_wdata),
    .ch_grant    (ch_grant),
    .ch_beat_ack (ch_beat_ack),
    .ch_done     (ch_done),
    .ch_err      (ch_err),
    .axi_awid    (axi_awid),
    .axi_awaddr  (axi_awaddr),
    .axi_awlen   (axi_awlen),
    .axi_awsize  (axi_awsize),
    .axi_awburst (axi_awburst),
    .axi_awvalid (axi_awvalid),
    .axi_awready (axi_awready),
    .axi_wdata   (axi_wdata),
    .axi_wstrb   (axi_wstrb),
    .axi_wlast   (axi_wlast),
    .axi_wvalid  (axi_wvalid),
    .axi_wready  (axi_wready),
    .axi_bid     (axi_bid),
    .axi_bresp   (axi_bresp),
    .axi_bvalid  (axi_bvalid),
    .axi_bready  (axi_bready)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Leave each step 2 time units after the rising edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [NCH-1:0] oh(input int c);
    logic [NCH-1:0] r;
    r = '0;
    r[c] = 1'b1;
    return r;
  endfunction

  // Round-robin as "smallest forward distance from the last winner".
  function automatic int rr_pick(input logic [NCH-1:0] m, input int p);
    int best, bd;
    best = -1;
    bd   = NCH + 1;
    for (int c = 0; c < NCH; c++) begin
      if (m[c]) begin
        int d;
        d = (c - p - 1 + 2 * NCH) % NCH;
        if (d < bd) begin
          bd   = d;
          best = c;
        end
      end
    end
    return best;
  endfunction

  function automatic bit is_illegal(input logic [31:0] a, input logic [7:0] l);
    int beats, endb;
    beats = int'(l) + 1;
    endb  = int'(a % 4096) + beats * (DW / 8);
    return (beats > MBL) || (endb > 4096);
  endfunction

  function automatic logic [63:0] word(input int c, input int k);
    return {8'(c), 8'(k), m_salt[c][15:0], (32'(k) * 32'h9E3779B1) ^ m_salt[c]};
  endfunction

  task automatic set_req(input int c, input logic [31:0] a, input logic [7:0] l);
    m_addr[c] = a;
    m_len[c]  = l;
    m_salt[c] = $urandom;
    ch_addr[c*AWD +: AWD] = a;
    ch_len[c*8 +: 8]      = l;
    ch_req[c]             = 1'b1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_grant"},   ch_grant,    '0);
    chk({tag, "_ack"},     ch_beat_ack, '0);
    chk({tag, "_done"},    ch_done,     '0);
    chk({tag, "_err"},     ch_err,      '0);
    chk({tag, "_awvalid"}, axi_awvalid, 0);
    chk({tag, "_awid"},    axi_awid,    0);
    chk({tag, "_awaddr"},  axi_awaddr,  0);
    chk({tag, "_awlen"},   axi_awlen,   0);
    chk({tag, "_wvalid"},  axi_wvalid,  0);
    chk({tag, "_wlast"},   axi_wlast,   0);
    chk({tag, "_wdata"},   axi_wdata,   0);
    chk({tag, "_bready"},  axi_bready,  0);
    chk({tag, "_awsize"},  axi_awsize,  3);
    chk({tag, "_awburst"}, axi_awburst, 1);
    chk({tag, "_wstrb"},   axi_wstrb,   8'hFF);
  endtask

  // One complete arbitration + burst, starting in IDLE with requests set up.
  // wmode: 0 wready always 1, 1 toggling 1/0, 2 random.
  task automatic do_burst(input int wmode, input int aw_dly, input int b_dly,
                          input logic [1:0] bresp, input bit bad_bid);
    int   c, k, acks, cyc;
    bit   ill, exp_err;
    logic wr;
    c = rr_pick(ch_req, model_ptr);
    if (c >= 0) begin
      ill = is_illegal(m_addr[c], m_len[c]);
      for (int i = 0; i < NCH * DW / 32; i++) ch_wdata[i*32 +: 32] = $urandom;
      step();
      model_ptr = c;
      // Post-grant changes on the request side must not matter.
      ch_addr[c*AWD +: AWD] = $urandom;
      ch_len[c*8 +: 8]      = 8'($urandom);
      #1;
      chk("grant", ch_grant, oh(c));
      if (ill) begin
        chk("rej_awvalid", axi_awvalid, 0);
        chk("rej_done", ch_done, oh(c));
        chk("rej_err", ch_err, oh(c));
        step();
        ch_req[c] = 1'b0;
        #1;
        chk("rej_exit_grant", ch_grant, '0);
        chk("rej_exit_done", ch_done, '0);
      end else begin
        chk("aw_valid", axi_awvalid, 1);
        chk("aw_id", axi_awid, 64'(c));
        chk("aw_addr", axi_awaddr, m_addr[c]);
        chk("aw_len", axi_awlen, m_len[c]);
        chk("aw_no_w", axi_wvalid, 0);
        for (int i = 0; i < aw_dly; i++) begin
          step();
          #1;
          chk("aw_hold", axi_awvalid, 1);
          chk("aw_hold_no_w", axi_wvalid, 0);
        end
        axi_awready = 1'b1;
        step();
        axi_awready = 1'b0;
        k = 0; acks = 0; cyc = 0;
        while (k <= int'(m_len[c]) && cyc < 1000) begin
          case (wmode)
            0:       wr = 1'b1;
            1:       wr = (cyc % 2 == 0);
            default: wr = (cyc > 500) ? 1'b1 : 1'($urandom_range(0, 1));
          endcase
          axi_wready = wr;
          ch_wdata[c*DW +: DW] = word(c, k);
          #1;
          chk("w_valid", axi_wvalid, 1);
          chk("w_no_aw", axi_awvalid, 0);
          chk("w_data", axi_wdata, word(c, k));
          chk("w_last", axi_wlast, 64'(k == int'(m_len[c])));
          chk("beat_ack", ch_beat_ack, wr ? oh(c) : '0);
          if (ch_beat_ack[c]) acks++;
          if (wr) k++;
          step();
          cyc++;
        end
        axi_wready = 1'b0;
        chk("beat_count", acks, int'(m_len[c]) + 1);
        for (int i = 0; i < b_dly; i++) begin
          #1;
          chk("b_ready_wait", axi_bready, 1);
          chk("b_no_w", axi_wvalid, 0);
          step();
        end
        axi_bvalid = 1'b1;
        axi_bresp  = bresp;
        axi_bid    = bad_bid ? IW'((c + 1) % NCH) : IW'(c);
        #1;
        chk("b_ready", axi_bready, 1);
        step();
        axi_bvalid = 1'b0;
        exp_err = (bresp != 2'b00) || bad_bid;
        #1;
        chk("done", ch_done, oh(c));
        chk("done_err", ch_err, exp_err ? oh(c) : '0);
        chk("done_bready", axi_bready, 0);
        chk("done_grant", ch_grant, oh(c));
        step();
        ch_req[c] = 1'b0;
        #1;
        chk("exit_grant", ch_grant, '0);
        chk("exit_done", ch_done, '0);
      end
    end
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] page, off;
    page = $urandom & 32'hFFFF_F000;
    off  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 511)) * 8
                                       : 32'($urandom_range(0, 63)) * 8;
    return page | off;
  endfunction

  function automatic logic [7:0] rand_len();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return 8'(MBL);
    if (r == 1) return 8'(MBL - 1);
    return 8'($urandom_range(0, 20));
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst         = 1'b1;
    ch_req      = '0;
    ch_addr     = '0;
    ch_len      = '0;
    ch_wdata    = '0;
    axi_awready = 1'b0;
    axi_wready  = 1'b0;
    axi_bid     = '0;
    axi_bresp   = '0;
    axi_bvalid  = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      m_addr[c] = '0; m_len[c] = '0; m_salt[c] = '0;
    end
    #2;
    chk_reset_outputs("reset");
    step();
    step();
    rst = 1'b0;
    model_ptr = NCH - 1;

    // Simultaneous ch0/ch2, then ch0 again: order 0, 2, 0.
    set_req(0, 32'h0000_2000, 8'd3);
    set_req(2, 32'h0000_3100, 8'd2);
    do_burst(0, 0, 0, 2'b00, 1'b0);
    set_req(0, 32'h0000_4000, 8'd1);
    do_burst(0, 0, 0, 2'b00, 1'b0);
    do_burst(0, 1, 0, 2'b00, 1'b0);

    // Basic ch1 burst, 8 beats.
    set_req(1, 32'h0000_1000, 8'd7);
    do_burst(0, 0, 0, 2'b00, 1'b0);

    // Toggling wready over 16 beats.
    set_req(2, 32'h0000_5000, 8'd15);
    do_burst(1, 1, 1, 2'b00, 1'b0);

    // Error responses, then normal service.
    set_req(3, 32'h0000_6000, 8'd4);
    do_burst(0, 0, 0, 2'b10, 1'b0);
    set_req(0, 32'h0000_7000, 8'd2);
    do_burst(0, 2, 0, 2'b00, 1'b1);
    set_req(1, 32'h0000_8000, 8'd0);
    do_burst(0, 0, 2, 2'b00, 1'b0);

    // Local rejection and legal boundary cases.
    set_req(3, 32'h0000_0FF8, 8'd1);
    do_burst(0, 0, 0, 2'b00, 1'b0);
    set_req(3, 32'h0000_0000, 8'(MBL));
    do_burst(0, 0, 0, 2'b00, 1'b0);
    set_req(3, 32'h0000_0000, 8'(MBL - 1));
    do_burst(0, 0, 0, 2'b00, 1'b0);
    set_req(3, 32'h0000_0FC0, 8'd7);
    do_burst(0, 0, 0, 2'b00, 1'b0);

    // Asynchronous reset while beat 5 of 16 is on the bus.
    set_req(1, 32'h0000_9000, 8'd15);
    step();
    #1;
    chk("rst_pre_grant", ch_grant, oh(1));
    chk("rst_pre_aw", axi_awvalid, 1);
    axi_awready = 1'b1;
    step();
    axi_awready = 1'b0;
    axi_wready  = 1'b1;
    for (int k = 0; k < 5; k++) begin
      ch_wdata[1*DW +: DW] = word(1, k);
      #1;
      chk("rst_pre_ack", ch_beat_ack, oh(1));
      step();
    end
    ch_wdata[1*DW +: DW] = word(1, 5);
    #1;
    chk("rst_pre_wvalid", axi_wvalid, 1);
    #1;
    rst = 1'b1;
    #1;
    chk_reset_outputs("async_rst");
    axi_wready = 1'b0;
    ch_req     = '0;
    step();
    step();
    rst = 1'b0;
    model_ptr = NCH - 1;
    set_req(3, 32'h0000_A000, 8'd2);
    set_req(0, 32'h0000_B000, 8'd2);
    do_burst(0, 0, 0, 2'b00, 1'b0);
    do_burst(2, 0, 0, 2'b00, 1'b0);

    // Randomized traffic.
    for (int it = 0; it < 40; it++) begin
      for (int c = 0; c < NCH; c++) begin
        if (!ch_req[c] && $urandom_range(0, 1) == 1) set_req(c, rand_addr(), rand_len());
      end
      if (ch_req == '0) set_req(int'($urandom_range(0, NCH - 1)), rand_addr(), rand_len());
      if ($urandom_range(0, 5) == 0 && $countones(ch_req) > 1) begin
        for (int c = 0; c < NCH; c++) begin
          if (ch_req[c] && $countones(ch_req) > 1 && $urandom_range(0, 1) == 1) ch_req[c] = 1'b0;
        end
      end
      do_burst(int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
               int'($urandom_range(0, 2)),
               ($urandom_range(0, 4) == 0) ? 2'b10 : 2'b00,
               $urandom_range(0, 6) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
